mem_ctrl: RTL and testbench

- Single-port memory arbiter between the instruction-fetch stage (IF) and the memory-access stage (MEM).
- Owns the byte-wide RAM bus: one byte address, one write-data byte and one write strobe per cycle.
- Grants the bus to one requester at a time and drives per-stage stall signals; the stalled stage's FSM freezes until granted.
- Sits directly downstream of MEM's re/we/addr/wdata outputs and upstream of the RAM.

---
 rtl/mem_ctrl_if.sv | 35 +++
 rtl/mem_ctrl.sv | 118 +++++++++++
 tb/tb_mem_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// Request/RAM bus bundle between the IF/MEM stages, the arbiter and the byte-wide RAM.
`ifndef STALL
`define STALL 2'b11
`endif
`ifndef NOSTALL
`define NOSTALL 2'b00
`endif

interface mem_ctrl_if #(
  parameter int ADDR_W  = 32,
  parameter int STALL_W = 2
);
  logic               re_IF_i;
  logic [ADDR_W-1:0]  addr_IF_i;
  logic [STALL_W-1:0] stl_IF_o;
  logic               re_MEM_i;
  logic               we_MEM_i;
  logic [ADDR_W-1:0]  addr_MEM_i;
  logic [7:0]         wdata_MEM_i;
  logic [STALL_W-1:0] stl_MEM_o;
  logic [ADDR_W-1:0]  mem_a_o;
  logic               mem_wr_o;
  logic [7:0]         mem_dout_o;
  logic [7:0]         mem_din_i;

  modport slave (
    input  re_IF_i, addr_IF_i, re_MEM_i, we_MEM_i, addr_MEM_i, wdata_MEM_i, mem_din_i,
    output stl_IF_o, stl_MEM_o, mem_a_o, mem_wr_o, mem_dout_o
  );

  modport master (
    output re_IF_i, addr_IF_i, re_MEM_i, we_MEM_i, addr_MEM_i, wdata_MEM_i, mem_din_i,
    input  stl_IF_o, stl_MEM_o, mem_a_o, mem_wr_o, mem_dout_o
  );
endinterface

// File: rtl/mem_ctrl.sv
// Single-port RAM arbiter between IF and MEM: grants the byte bus to one stage and stalls the other.
module mem_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int STALL_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy_in,
  mem_ctrl_if.slave   bus
);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_MEM  = 2'd2;
  localparam logic [1:0] HANDOVER = 2'd3;

  localparam logic [STALL_W-1:0] STL   = STALL_W'(`STALL);
  localparam logic [STALL_W-1:0] NOSTL = STALL_W'(`NOSTALL);

  logic [1:0]        r_own;
  logic [1:0]        w_own_nxt;
  logic              r_from_mem;
  logic              w_from_mem_nxt;
  logic [ADDR_W-1:0] r_last_a;
  logic [ADDR_W-1:0] w_a;
  logic              w_wr;
  logic [7:0]        w_dout;
  logic              w_req_if;
  logic              w_req_mem;
  logic              w_unused_din;

  assign w_req_if     = bus.re_IF_i;
  assign w_req_mem    = bus.re_MEM_i | bus.we_MEM_i;
  assign w_unused_din = ^bus.mem_din_i;

  // r_from_mem remembers who released the bus so HANDOVER can demote that stage once.
  always_comb begin
    w_own_nxt      = r_own;
    w_from_mem_nxt = r_from_mem;
    case (r_own)
      IDLE: begin
        if (w_req_mem)     w_own_nxt = OWN_MEM;
        else if (w_req_if) w_own_nxt = OWN_IF;
      end
      OWN_IF: begin
        if (!w_req_if) begin
          w_own_nxt      = w_req_mem ? HANDOVER : IDLE;
          w_from_mem_nxt = 1'b0;
        end
      end
      OWN_MEM: begin
        if (!w_req_mem) begin
          w_own_nxt      = w_req_if ? HANDOVER : IDLE;
          w_from_mem_nxt = 1'b1;
        end
      end
      default: begin
        if (r_from_mem) begin
          if (w_req_if)       w_own_nxt = OWN_IF;
          else if (w_req_mem) w_own_nxt = OWN_MEM;
          else                w_own_nxt = IDLE;
        end else begin
          if (w_req_mem)      w_own_nxt = OWN_MEM;
          else if (w_req_if)  w_own_nxt = OWN_IF;
          else                w_own_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_own      <= IDLE;
      r_from_mem <= 1'b0;
      r_last_a   <= '0;
    end else if (rdy_in) begin
      r_own      <= w_own_nxt;
      r_from_mem <= w_from_mem_nxt;
      r_last_a   <= w_a;
    end
  end

  always_comb begin
    w_a    = '0;
    w_wr   = 1'b0;
    w_dout = '0;
    case (r_own)
      OWN_IF:  w_a = bus.addr_IF_i;
      OWN_MEM: begin
        w_a    = bus.addr_MEM_i;
        w_wr   = bus.we_MEM_i;
        w_dout = bus.we_MEM_i ? bus.wdata_MEM_i : 8'h00;
      end
      default: ;
    endcase
  end

  // Reset forcing wins over the rdy_in freeze; a frozen bus replays the last driven address.
  always_comb begin
    bus.mem_a_o    = '0;
    bus.mem_wr_o   = 1'b0;
    bus.mem_dout_o = '0;
    bus.stl_IF_o   = NOSTL;
    bus.stl_MEM_o  = NOSTL;
    if (!rst) begin
      if (!rdy_in) begin
        bus.mem_a_o   = r_last_a;
        bus.stl_IF_o  = STL;
        bus.stl_MEM_o = STL;
      end else begin
        bus.mem_a_o    = w_a;
        bus.mem_wr_o   = w_wr;
        bus.mem_dout_o = w_dout;
        bus.stl_IF_o   = (w_req_if  && r_own != OWN_IF)  ? STL : NOSTL;
        bus.stl_MEM_o  = (w_req_mem && r_own != OWN_MEM) ? STL : NOSTL;
      end
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed scoreboard bench for mem_ctrl: expected bus/stall values queued per cycle, checked at negedge.
`ifndef STALL
`define STALL 2'b11
`endif
`ifndef NOSTALL
`define NOSTALL 2'b00
`endif

module tb_mem_ctrl;
  localparam logic [1:0] STL = `STALL;
  localparam logic [1:0] NOS = `NOSTALL;

  typedef struct {
    string       tag;
    logic [31:0] a;
    logic        wr;
    logic [7:0]  dout;
    logic [1:0]  sif;
    logic [1:0]  smem;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic rdy_in;
  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  mem_ctrl_if #(.ADDR_W(32), .STALL_W(2)) bus ();

  mem_ctrl #(.ADDR_W(32), .STALL_W(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .rdy_in (rdy_in),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic drv(input logic rst_v, input logic rdy_v, input logic re_if, input logic [31:0] a_if,
                     input logic re_m, input logic we_m, input logic [31:0] a_m, input logic [7:0] wd);
    rst             = rst_v;
    rdy_in          = rdy_v;
    bus.re_IF_i     = re_if;
    bus.addr_IF_i   = a_if;
    bus.re_MEM_i    = re_m;
    bus.we_MEM_i    = we_m;
    bus.addr_MEM_i  = a_m;
    bus.wdata_MEM_i = wd;
  endtask

  task automatic step(input string tag, input logic [31:0] a, input logic wr, input logic [7:0] dout,
                      input logic [1:0] sif, input logic [1:0] smem);
    exp_t e;
    e.tag = tag; e.a = a; e.wr = wr; e.dout = dout; e.sif = sif; e.smem = smem;
    q.push_back(e);
    @(negedge clk);
    e = q.pop_front();
    total++;
    assert (bus.mem_a_o === e.a) else begin
      bad++; $error("FAIL %s.mem_a got=%h exp=%h", e.tag, bus.mem_a_o, e.a);
    end
    total++;
    assert (bus.mem_wr_o === e.wr) else begin
      bad++; $error("FAIL %s.mem_wr got=%b exp=%b", e.tag, bus.mem_wr_o, e.wr);
    end
    total++;
    assert (bus.mem_dout_o === e.dout) else begin
      bad++; $error("FAIL %s.mem_dout got=%h exp=%h", e.tag, bus.mem_dout_o, e.dout);
    end
    total++;
    assert (bus.stl_IF_o === e.sif) else begin
      bad++; $error("FAIL %s.stl_IF got=%b exp=%b", e.tag, bus.stl_IF_o, e.sif);
    end
    total++;
    assert (bus.stl_MEM_o === e.smem) else begin
      bad++; $error("FAIL %s.stl_MEM got=%b exp=%b", e.tag, bus.stl_MEM_o, e.smem);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.mem_din_i = 8'h00;
    drv(1, 1, 0, 0, 0, 0, 0, 0);
    step("rst", 0, 0, 0, NOS, NOS);
    drv(0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("idle", 0, 0, 0, NOS, NOS);

    // IF alone
    drv(0, 1, 1, 32'h100, 0, 0, 0, 0);
    step("if_grant", 0, 0, 0, STL, NOS);
    step("if_own0", 32'h100, 0, 0, NOS, NOS);
    step("if_own1", 32'h100, 0, 0, NOS, NOS);
    drv(0, 1, 0, 32'h100, 0, 0, 0, 0);
    step("if_drop", 32'h100, 0, 0, NOS, NOS);
    step("if_idle", 0, 0, 0, NOS, NOS);

    // Both request in IDLE: MEM store wins
    drv(0, 1, 1, 32'h200, 0, 1, 32'h1000, 8'hA5);
    step("both_idle", 0, 0, 0, STL, STL);
    step("mem_wr0", 32'h1000, 1, 8'hA5, STL, NOS);
    step("mem_wr1", 32'h1000, 1, 8'hA5, STL, NOS);
    drv(0, 1, 1, 32'h200, 0, 0, 32'h1000, 8'hA5);
    step("mem_drop", 32'h1000, 0, 0, STL, NOS);
    // HANDOVER after MEM: MEM re-requests but IF has priority
    drv(0, 1, 1, 32'h200, 1, 0, 32'h1004, 8'h00);
    step("ho_mem", 0, 0, 0, STL, STL);
    step("if_own2", 32'h200, 0, 0, NOS, STL);
    step("if_own3", 32'h200, 0, 0, NOS, STL);
    drv(0, 1, 0, 32'h200, 1, 0, 32'h1004, 8'h00);
    step("if_drop2", 32'h200, 0, 0, NOS, STL);
    step("ho_if", 0, 0, 0, NOS, STL);
    step("mem_rd", 32'h1004, 0, 0, NOS, NOS);

    // re+we together is a write; then freeze with rdy_in low
    drv(0, 1, 0, 0, 1, 1, 32'h2000, 8'h3C);
    step("mem_rw", 32'h2000, 1, 8'h3C, NOS, NOS);
    drv(0, 0, 0, 0, 1, 1, 32'h2004, 8'h3C);
    for (int i = 0; i < 3; i++) step("frz", 32'h2000, 0, 0, STL, STL);
    drv(0, 1, 0, 0, 1, 1, 32'h2004, 8'h3C);
    step("resume", 32'h2004, 1, 8'h3C, NOS, NOS);

    // Reset pulse mid-store, then re-arbitration from IDLE
    drv(1, 1, 1, 32'h300, 0, 1, 32'h2004, 8'h3C);
    step("rst_mid", 0, 0, 0, NOS, NOS);
    drv(0, 1, 1, 32'h300, 0, 1, 32'h2004, 8'h3C);
    step("rearb", 0, 0, 0, STL, STL);
    step("mem_again", 32'h2004, 1, 8'h3C, STL, NOS);
    drv(0, 1, 0, 0, 0, 0, 0, 0);
    step("rel_all", 0, 0, 0, NOS, NOS);
    step("end_idle", 0, 0, 0, NOS, NOS);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
